// File: rtl/register_file_pkg.sv
// Core-wide types shared by the register file and its neighbours in the
// RV32I pipeline: data width, register index type, writeback write bundle
// and the packed view of the x1..x31 storage.
package register_file_pkg;

  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0] rv_reg_t;

  typedef struct packed {
    logic            enable;
    rv_reg_t         which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;

  // Storage for x1..x31 only; x0 is hard-wired zero and has no flops.
  typedef logic [NUM_REGS-1:1][XLEN-1:0] reg_array_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port of the integer register file.
// Selects a stored register by index, returns zero for x0, and, when built
// with REGISTER_FILE_BYPASS_EN, forwards a same-cycle writeback value.
module register_file_read_port
  import register_file_pkg::*;
(
  input  rv_reg_t            index,
  input  reg_array_t         regs,
`ifdef REGISTER_FILE_BYPASS_EN
  input  reg_write_control_t fwd,
`endif
  output logic [XLEN-1:0]    value
);

  // Read mux: x0 never matches the loop so it falls through to zero;
  // an in-flight write to the same register takes priority when forwarding.
  always_comb begin
    value = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (index == rv_reg_t'(i)) begin
        value = regs[i];
      end
    end
`ifdef REGISTER_FILE_BYPASS_EN
    if (fwd.enable && (fwd.which_register != '0) && (fwd.which_register == index)) begin
      value = fwd.value;
    end
`endif
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 31 XLEN-bit registers (x0 reads zero),
// two combinational read ports for decode, one synchronous write port
// for writeback. Asynchronous active-high reset clears every register.
// Optional macro REGISTER_FILE_BYPASS_EN adds write-to-read forwarding.
module register_file
  import register_file_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  rv_reg_t            rs1,
  input  rv_reg_t            rs2,
  input  reg_write_control_t write_control,
  output logic [XLEN-1:0]    rs1_val,
  output logic [XLEN-1:0]    rs2_val
);

  reg_array_t regs;

  // Write port: writes to x0 or with enable low leave state untouched;
  // reset wins over a write on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (write_control.enable && (write_control.which_register != '0)) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (write_control.which_register == rv_reg_t'(i)) begin
          regs[i] <= write_control.value;
        end
      end
    end
  end

`ifdef REGISTER_FILE_BYPASS_EN
  reg_write_control_t fwd;

  // Forwarding is masked during reset so the ports read zero while it is held.
  always_comb begin
    fwd = write_control;
    if (reset) begin
      fwd.enable = 1'b0;
    end
  end
`endif

  register_file_read_port u_port1 (
    .index (rs1),
    .regs  (regs),
`ifdef REGISTER_FILE_BYPASS_EN
    .fwd   (fwd),
`endif
    .value (rs1_val)
  );

  register_file_read_port u_port2 (
    .index (rs2),
    .regs  (regs),
`ifdef REGISTER_FILE_BYPASS_EN
    .fwd   (fwd),
`endif
    .value (rs2_val)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference array of register
// contents feeds an expected-value queue at each read, and the queue is
// drained against the DUT read ports.
module tb_register_file;
  import register_file_pkg::*;

  logic               clock;
  logic               reset;
  rv_reg_t            rs1;
  rv_reg_t            rs2;
  reg_write_control_t write_control;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;

  register_file dut (
    .clock         (clock),
    .reset         (reset),
    .rs1           (rs1),
    .rs2           (rs2),
    .write_control (write_control),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [XLEN-1:0] model [NUM_REGS];
  logic [XLEN-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // Expected value of a read port in the current cycle.
  function automatic logic [XLEN-1:0] expect_read(input rv_reg_t idx);
    logic [XLEN-1:0] v;
    v = (idx == 5'd0) ? '0 : model[idx];
`ifdef REGISTER_FILE_BYPASS_EN
    if (!reset && write_control.enable && write_control.which_register != 5'd0 &&
        write_control.which_register == idx)
      v = write_control.value;
`endif
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive both read indices, push expectations, then drain against the DUT.
  task automatic read_check(input string tag, input rv_reg_t a, input rv_reg_t b);
    rs1 = a;
    rs2 = b;
    exp_q.push_back(expect_read(a));
    exp_q.push_back(expect_read(b));
    #1;
    check({tag, ".rs1"}, rs1_val, exp_q.pop_front());
    check({tag, ".rs2"}, rs2_val, exp_q.pop_front());
  endtask

  // Present a write at the negedge; pre_tag reads are done before the edge.
  task automatic setup_write(input logic en, input rv_reg_t r, input logic [XLEN-1:0] v);
    @(negedge clock);
    write_control.enable         = en;
    write_control.which_register = r;
    write_control.value          = v;
  endtask

  // Let the capturing edge happen, update the model, then drop enable.
  task automatic commit_write();
    @(posedge clock);
    if (!reset && write_control.enable && write_control.which_register != 5'd0)
      model[write_control.which_register] = write_control.value;
    #1;
    write_control.enable = 1'b0;
  endtask

  task automatic do_write(input logic en, input rv_reg_t r, input logic [XLEN-1:0] v);
    setup_write(en, r, v);
    commit_write();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_model();
    reset = 1'b1;
    rs1 = '0;
    rs2 = '0;
    write_control = '0;

    // Reset state, sampled while reset held and after release.
    #2;
    read_check("reset_held", 5'd0, 5'd5);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    read_check("reset_released", 5'd0, 5'd5);

    // Disabled write must not land.
    do_write(1'b0, 5'd5, 32'hCAFEBABE);
    read_check("write_disabled", 5'd0, 5'd5);

    // Enabled write: pre-edge view depends on forwarding, post-edge must land.
    setup_write(1'b1, 5'd5, 32'hCAFEBABE);
    #1;
    read_check("pre_edge", 5'd5, 5'd5);
    commit_write();
    read_check("post_edge", 5'd5, 5'd5);
    check("post_edge_const", rs2_val, 32'hCAFEBABE);

    // Write to x0 is ignored, before and after the edge.
    setup_write(1'b1, 5'd0, 32'hDEADBEEF);
    #1;
    read_check("x0_pre", 5'd0, 5'd0);
    commit_write();
    read_check("x0_post", 5'd0, 5'd5);

    // X on the bundle with enable low has no effect.
    @(negedge clock);
    write_control.enable         = 1'b0;
    write_control.which_register = 'x;
    write_control.value          = 'x;
    @(posedge clock);
    #1;
    write_control = '0;
    read_check("x_disabled", 5'd5, 5'd6);

    // Boundary registers x31 and x1, then sweep all registers.
    do_write(1'b1, 5'd31, 32'h12345678);
    do_write(1'b1, 5'd1,  32'hFFFFFFFF);
    read_check("x31_x1", 5'd31, 5'd1);
    check("x31_const", rs1_val, 32'h12345678);
    check("x1_const",  rs2_val, 32'hFFFFFFFF);
    for (int i = 0; i < NUM_REGS; i += 2)
      read_check($sformatf("sweep_%0d", i), rv_reg_t'(i), rv_reg_t'(i + 1));

    // Random writes followed by random dual reads.
    for (int k = 0; k < 40; k++) begin
      do_write($urandom_range(0, 3) != 0, rv_reg_t'($urandom_range(0, 31)), $urandom);
      read_check($sformatf("rand_%0d", k),
                 rv_reg_t'($urandom_range(0, 31)), rv_reg_t'($urandom_range(0, 31)));
    end

    // Asynchronous reset between edges clears everything immediately.
    do_write(1'b1, 5'd7, 32'hA5A5A5A5);
    @(negedge clock);
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    read_check("async_reset", 5'd7, 5'd31);
    // Write presented on an edge while reset is asserted is dropped.
    write_control.enable         = 1'b1;
    write_control.which_register = 5'd9;
    write_control.value          = 32'h0BADF00D;
    #1;
    read_check("reset_fwd_masked", 5'd9, 5'd1);
    commit_write();
    @(negedge clock);
    reset = 1'b0;
    #1;
    read_check("after_release", 5'd9, 5'd5);
    for (int i = 0; i < NUM_REGS; i += 2)
      read_check($sformatf("post_reset_%0d", i), rv_reg_t'(i), rv_reg_t'(i + 1));

    // First write after release lands on the next edge.
    do_write(1'b1, 5'd9, 32'h13572468);
    read_check("first_write", 5'd9, 5'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
